// File: rtl/cpu_pkg.sv
// Shared CPU definitions: funct3 access sizes, opcodes, LSU state and the
// data-memory request bundle.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  // Registered data-memory request (everything except the req strobe)
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dm_req_t;

  // Signedness is irrelevant to the memory access; undefined codes act as W
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// Store alignment: funct3/addr/data -> per-lane byte strobes, lane-replicated
// write data and a misalignment flag. Purely combinational.
module mem_store_align
  import cpu_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [2:0]                         funct3,
  input  logic [$clog2(NUM_LANES)-1:0]       addr,
  input  logic [NUM_LANES*VEC_W-1:0]         data,
  output logic [NUM_LANES-1:0]               wstrb,
  output logic [NUM_LANES-1:0][VEC_W-1:0]    wdata,
  output logic                               misaligned
);

  localparam int AW = $clog2(NUM_LANES);

  acc_size_e sz;
  assign sz = f3_size(funct3);

  // Halfwords need even addresses, words need lane 0
  assign misaligned = ((sz == SZ_H) && addr[0]) || ((sz == SZ_W) && (addr != '0));

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [AW-1:0] LANE = AW'(i);
      // Lane enabled when it falls inside the addressed byte/half/word
      assign wstrb[i] = (sz == SZ_W)
                      | ((sz == SZ_H) & (addr[AW-1:1] == LANE[AW-1:1]))
                      | ((sz == SZ_B) & (addr == LANE));
      // Replicate the low byte/half across the word so any lane can take it
      assign wdata[i] = (sz == SZ_W) ? data[i*VEC_W +: VEC_W]
                      : (sz == SZ_H) ? data[(i%2)*VEC_W +: VEC_W]
                      :                data[VEC_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ready handshake to data memory, byte strobes,
// lane-aligned load word, and the MEM/WB advance enable.
// Optional watchdog: define MEM_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles without dm_ready (adds the bus_timeout output).
module mem_stage_lsu
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Memread,
  input  logic        MEM_Memwrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_store_data,
  input  logic        stage_adv,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic [31:0] MEM_data_out,
  output logic        mem_advance,
  output logic        misalign
`ifdef MEM_TIMEOUT_EN
  ,output logic       bus_timeout
`endif
);

  lsu_state_e state, state_n;
  dm_req_t    req_q;
  logic [1:0] addr_lo;
  logic       op_vld, is_st, al_mis, tmo_hit;
  logic [3:0] al_wstrb;
  logic [31:0] al_wdata;

  assign op_vld = MEM_Memread | MEM_Memwrite;
  assign is_st  = MEM_Memwrite;   // read+write together is a store

  mem_store_align #(.NUM_LANES(4), .VEC_W(8)) u_align (
    .funct3     (MEM_funct3),
    .addr       (MEM_addr[1:0]),
    .data       (MEM_store_data),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .misaligned (al_mis)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : TW_RAW;
  logic [TW-1:0] tmo_cnt;
  // Counter holds the number of ACCESS cycles already spent without dm_ready
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
  // The watchdog limit has no effect without the watchdog
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_cfg_unused
  end
`endif

  assign dm_we    = req_q.we;
  assign dm_addr  = req_q.addr;
  assign dm_wstrb = req_q.wstrb;
  assign dm_wdata = req_q.wdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and advance enable
  always_comb begin
    state_n     = state;
    mem_advance = 1'b0;
    unique case (state)
      IDLE: begin
        mem_advance = ~op_vld;
        if (op_vld) state_n = al_mis ? DONE : ACCESS;
      end
      ACCESS: begin
        if (dm_ready || tmo_hit) state_n = DONE;
      end
      DONE: begin
        mem_advance = 1'b1;
        if (stage_adv) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request, load capture and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req       <= 1'b0;
      req_q        <= '0;
      addr_lo      <= 2'b00;
      MEM_data_out <= '0;
      misalign     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt      <= '0;
      bus_timeout  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (op_vld) begin
            if (al_mis) begin
              misalign <= 1'b1;
            end else begin
              dm_req      <= 1'b1;
              req_q.we    <= is_st;
              req_q.addr  <= {MEM_addr[31:2], 2'b00};
              req_q.wstrb <= is_st ? al_wstrb : 4'b0000;
              req_q.wdata <= is_st ? al_wdata : 32'h0;
              addr_lo     <= MEM_addr[1:0];
`ifdef MEM_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
            end
          end
        end
        ACCESS: begin
          if (dm_ready) begin
            dm_req <= 1'b0;
            if (!req_q.we) MEM_data_out <= dm_rdata >> {addr_lo, 3'b000};
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            dm_req       <= 1'b0;
            bus_timeout  <= 1'b1;
            MEM_data_out <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (stage_adv) begin
            misalign    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_timeout <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: hand vector table, hand sequences for hold and
// async reset, then random ops against a byte-level reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Memread, MEM_Memwrite, stage_adv, dm_ready;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_addr, MEM_store_data, dm_rdata;
  logic        dm_req, dm_we, mem_advance, misalign;
  logic [31:0] dm_addr, dm_wdata, MEM_data_out;
  logic [3:0]  dm_wstrb;
`ifdef MEM_TIMEOUT_EN
  logic        bus_timeout;
`endif

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .MEM_Memread(MEM_Memread), .MEM_Memwrite(MEM_Memwrite),
    .MEM_funct3(MEM_funct3), .MEM_addr(MEM_addr),
    .MEM_store_data(MEM_store_data), .stage_adv(stage_adv),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .MEM_data_out(MEM_data_out), .mem_advance(mem_advance),
    .misalign(misalign)
`ifdef MEM_TIMEOUT_EN
    ,.bus_timeout(bus_timeout)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_dout;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, data, rdata;
    int          wt;      // wait cycles before dm_ready
    logic        mis;
    logic [3:0]  wstrb;
    logic [31:0] wdata, dout;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } enc_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: access size from funct3, then per-byte rules
  function automatic enc_t model_enc(input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] data);
    enc_t e;
    int size, off, base;
    size = (f3 == 3'b000 || f3 == 3'b100) ? 1 :
           (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    off  = int'(addr % 4);
    base = off - (off % size);
    e.mis   = (off % size) != 0;
    e.wstrb = '0;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= base && i < base + size) e.wstrb[i] = 1'b1;
      e.wdata[i*8 +: 8] = data[(i % size)*8 +: 8];
    end
    return e;
  endfunction

  task automatic clear_op();
    MEM_Memread = 0; MEM_Memwrite = 0; MEM_funct3 = 0;
    MEM_addr = 0; MEM_store_data = 0;
  endtask

  task automatic do_release();
    stage_adv = 1;
    clear_op();
    @(negedge clk);
    stage_adv = 0;
    chk("rel_misalign", misalign, 0);
    chk("rel_adv", mem_advance, 1);
    chk("rel_req", dm_req, 0);
  endtask

  // Present op at a negedge (IDLE), walk it through ACCESS into DONE
  task automatic do_op(input vec_t v, input bit rel);
    MEM_Memread = v.rd; MEM_Memwrite = v.wr; MEM_funct3 = v.f3;
    MEM_addr = v.addr; MEM_store_data = v.data;
    stage_adv = 0; dm_ready = 0;
    #1 chk("adv_op_idle", mem_advance, 0);
    @(negedge clk);
    if (v.mis) begin
      chk("mis_flag", misalign, 1);
      chk("mis_noreq", dm_req, 0);
      chk("mis_adv", mem_advance, 1);
    end else begin
      for (int k = 0; k <= v.wt; k++) begin
        chk("req_hi", dm_req, 1);
        chk("req_adv", mem_advance, 0);
        chk("req_addr", dm_addr, {v.addr[31:2], 2'b00});
        chk("req_we", dm_we, v.wr);
        chk("req_wstrb", dm_wstrb, v.wstrb);
        if (v.wr) chk("req_wdata", dm_wdata, v.wdata);
        dm_ready = (k == v.wt);
        dm_rdata = (k == v.wt) ? v.rdata : $urandom;
        @(negedge clk);
      end
      dm_ready = 0;
      dm_rdata = $urandom;
      chk("done_req", dm_req, 0);
      chk("done_adv", mem_advance, 1);
      chk("done_misalign", misalign, 0);
    end
    chk("dout", MEM_data_out, v.dout);
    if (rel) do_release();
  endtask

  vec_t tbl[12];
  vec_t v;
  enc_t e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //   rd wr f3      addr          data          rdata         wt mis wstrb    wdata          dout
    tbl[0]  = '{0,1,3'b010,32'h100,32'hDEADBEEF,32'h0,       0, 0,4'b1111,32'hDEADBEEF,32'h0};
    tbl[1]  = '{0,1,3'b000,32'h103,32'h000000A5,32'h0,       0, 0,4'b1000,32'hA5A5A5A5,32'h0};
    tbl[2]  = '{1,0,3'b001,32'h202,32'h0,       32'h80011234,3, 0,4'b0000,32'h0,       32'h00008001};
    tbl[3]  = '{1,0,3'b010,32'h301,32'h0,       32'h0,       0, 1,4'b0000,32'h0,       32'h00008001};
    tbl[4]  = '{0,1,3'b001,32'h106,32'h1234ABCD,32'h0,       1, 0,4'b1100,32'hABCDABCD,32'h00008001};
    tbl[5]  = '{1,0,3'b100,32'h10B,32'h0,       32'h11223344,1, 0,4'b0000,32'h0,       32'h00000011};
    tbl[6]  = '{1,1,3'b010,32'h040,32'hCAFEF00D,32'h99999999,0, 0,4'b1111,32'hCAFEF00D,32'h00000011};
    tbl[7]  = '{1,0,3'b011,32'h044,32'h0,       32'h55667788,2, 0,4'b0000,32'h0,       32'h55667788};
    tbl[8]  = '{0,1,3'b110,32'h046,32'h12345678,32'h0,       0, 1,4'b0000,32'h0,       32'h55667788};
    tbl[9]  = '{0,1,3'b001,32'h101,32'h12345678,32'h0,       0, 1,4'b0000,32'h0,       32'h55667788};
    tbl[10] = '{1,0,3'b000,32'h201,32'h0,       32'hAABBCCDD,0, 0,4'b0000,32'h0,       32'h00AABBCC};
    tbl[11] = '{0,1,3'b101,32'h100,32'h0000BEEF,32'h0,       0, 0,4'b0011,32'hBEEFBEEF,32'h00AABBCC};

    // Reset state
    rst = 1; clear_op(); stage_adv = 0; dm_ready = 0; dm_rdata = 0;
    #2;
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wstrb", dm_wstrb, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_dout", MEM_data_out, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_adv", mem_advance, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("idle_adv", mem_advance, 1);
    last_dout = 0;

    // Hand vectors
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i], 1'b1);
      last_dout = tbl[i].dout;
    end

    // DONE held with no stage_adv: no re-issue, output stable
    v = '{1,0,3'b010,32'h20,32'h0,32'h0BADF00D,1,0,4'b0000,32'h0,32'h0BADF00D};
    do_op(v, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_req", dm_req, 0);
      chk("hold_dout", MEM_data_out, 32'h0BADF00D);
      chk("hold_adv", mem_advance, 1);
    end
    do_release();

    // Async reset during ACCESS
    MEM_Memwrite = 1; MEM_funct3 = 3'b010; MEM_addr = 32'h80; MEM_store_data = 32'h13572468;
    @(negedge clk);
    chk("ar_req_before", dm_req, 1);
    #2 rst = 1;
    #1;
    chk("ar_req", dm_req, 0);
    chk("ar_we", dm_we, 0);
    chk("ar_addr", dm_addr, 0);
    chk("ar_wstrb", dm_wstrb, 0);
    chk("ar_wdata", dm_wdata, 0);
    chk("ar_dout", MEM_data_out, 0);
    clear_op();
    @(negedge clk);
    rst = 0;
    last_dout = 0;
    @(negedge clk);
    chk("ar_idle_adv", mem_advance, 1);
    chk("ar_idle_req", dm_req, 0);

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3s [8] = '{3'b000,3'b001,3'b010,3'b100,3'b101,3'b011,3'b110,3'b111};
      v.wr    = $urandom_range(0, 1);
      v.rd    = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.f3    = f3s[$urandom_range(0, 7)];
      v.addr  = $urandom;
      v.data  = $urandom;
      v.rdata = $urandom;
      v.wt    = $urandom_range(0, 3);
      e       = model_enc(v.f3, v.addr, v.data);
      v.mis   = e.mis;
      v.wstrb = v.wr ? e.wstrb : 4'b0000;
      v.wdata = e.wdata;
      v.dout  = (v.mis || v.wr) ? last_dout : (v.rdata >> (8 * (v.addr % 4)));
      do_op(v, 1'b1);
      last_dout = v.dout;
    end

`ifdef MEM_TIMEOUT_EN
    // Watchdog: dm_ready never comes
    MEM_Memread = 1; MEM_funct3 = 3'b010; MEM_addr = 32'h10;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("tmo_req_hi", dm_req, 1);
      @(negedge clk);
    end
    chk("tmo_req_lo", dm_req, 0);
    chk("tmo_flag", bus_timeout, 1);
    chk("tmo_dout", MEM_data_out, 0);
    chk("tmo_adv", mem_advance, 1);
    do_release();
    chk("tmo_flag_clr", bus_timeout, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
